// File: rtl/counter_pkg.sv
// Shared constants for the configurable counter: mode and direction encodings.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Step divider: issues a tick once every prescale+1 enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;

  assign tick = ena & (pre_cnt == prescale);

  // A prescale lowered below pre_cnt falls into the >= branch: wrap without a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (ena) begin
      if (restart || (pre_cnt >= prescale)) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter_nb.sv
// Configurable N-bit counter: up/down, load, clear, modulus, prescaler and
// wrap/saturate/one-shot terminal behaviour; tc is a one-cycle registered tick.
module mod_counter_nb
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4,
  parameter int RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic             tick;
  logic             terminal;
  logic             step;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             done_nxt;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .restart  (clr | load),
    .prescale (prescale),
    .tick     (tick)
  );

  // Up-count uses >= so a count loaded above modulus still terminates and wraps.
  always_comb begin
    terminal  = (dir == DIR_UP) ? (count >= modulus) : (count == '0);
    step      = tick & ~clr & ~load & ~((mode == MODE_ONESHOT) & done);
    count_nxt = count;
    done_nxt  = done;
    tc_nxt    = 1'b0;

    if (ena && clr) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (ena && load) begin
      count_nxt = load_val;
      done_nxt  = 1'b0;
    end else if (step) begin
      if (terminal) begin
        tc_nxt = 1'b1;
        case (mode)
          MODE_SAT:     count_nxt = count;
          MODE_ONESHOT: done_nxt  = 1'b1;
          default:      count_nxt = (dir == DIR_UP) ? '0 : modulus;
        endcase
      end else begin
        count_nxt = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_COUNT;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

endmodule
